// File: rtl/bist_response_controller.sv
// BIST sequencer: runs the TPG/MISR for N_PATTERNS cycles, checks the signature.
// Optional BIST_SIG_LATCH_EN adds the sig_latched debug capture port.
module bist_response_controller #(
   parameter int unsigned       N_PATTERNS = 8,
   parameter int unsigned       CNT_W      = 4,
   parameter logic [4:1]        GOLDEN_SIG = 4'hA
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [4:1]       dataout_misr,
   output logic             tpg_load,
   output logic             test_en,
   output logic             misr_rst_n,
   output logic [CNT_W-1:0] pat_cnt,
   output logic             busy,
   output logic             bist_done,
   output logic             bist_pass
`ifdef BIST_SIG_LATCH_EN
   ,
   output logic [4:1]       sig_latched
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      RUN     = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);

   state_e           state_q, state_d;
   logic             start_q;
   logic             tpg_load_q;
   logic             test_en_q;
   logic             misr_rst_n_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;

   // Launch decisions use the registered copy of start.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_q) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE:    if (start_q) state_d = INIT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         tpg_load_q   <= 1'b0;
         test_en_q    <= 1'b0;
         misr_rst_n_q <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         tpg_load_q   <= (state_d == INIT);
         test_en_q    <= (state_d == RUN);
         misr_rst_n_q <= (state_d inside {RUN, COMPARE, DONE});
         busy_q       <= (state_d inside {INIT, RUN, COMPARE});
         case (state_d)
            IDLE, INIT: begin
               cnt_q  <= '0;
               done_q <= 1'b0;
               pass_q <= 1'b0;
            end
            RUN: begin
               cnt_q <= (state_q == RUN) ? cnt_q + CNT_W'(1) : '0;
            end
            COMPARE: begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            DONE: begin
               if (state_q == COMPARE) begin
                  done_q <= 1'b1;
                  pass_q <= (dataout_misr == GOLDEN_SIG);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BIST_SIG_LATCH_EN
   logic [4:1] sig_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sig_q <= '0;
      end else if (state_q == COMPARE) begin
         sig_q <= dataout_misr;
      end else if (state_d == INIT) begin
         sig_q <= '0;
      end
   end

   assign sig_latched = sig_q;
`endif

   assign tpg_load   = tpg_load_q;
   assign test_en    = test_en_q;
   assign misr_rst_n = misr_rst_n_q;
   assign pat_cnt    = cnt_q;
   assign busy       = busy_q;
   assign bist_done  = done_q;
   assign bist_pass  = pass_q;

endmodule

// File: tb/tb_bist_response_controller.sv
// Scoreboard bench for bist_response_controller: directed cases plus random runs.
module tb_bist_response_controller;

   localparam int         N    = 8;
   localparam logic [3:0] GOLD = 4'hA;
   localparam int         LAT  = N + 3;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [4:1] misr;
   logic       tpg_load;
   logic       test_en;
   logic       misr_rst_n;
   logic [3:0] pat_cnt;
   logic       busy;
   logic       bist_done;
   logic       bist_pass;
`ifdef BIST_SIG_LATCH_EN
   logic [4:1] sig_latched;
`endif

   typedef struct {
      int         done_cyc;
      logic       pass;
      logic [3:0] sig;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   skip_len = 0;

   bist_response_controller dut (
      .clock       (clk),
      .reset       (rst_n),
      .start       (start),
      .abort       (abort),
      .dataout_misr(misr),
      .tpg_load    (tpg_load),
      .test_en     (test_en),
      .misr_rst_n  (misr_rst_n),
      .pat_cnt     (pat_cnt),
      .busy        (busy),
      .bist_done   (bist_done),
      .bist_pass   (bist_pass)
`ifdef BIST_SIG_LATCH_EN
      ,
      .sig_latched (sig_latched)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: condition not reached t=%0t", nm, $time);
   endtask

   // Monitor: per-run shape checks and scoreboard pop on each new result.
   initial begin
      bit   prev_te   = 0;
      bit   prev_done = 0;
      int   te_n      = 0;
      int   tpg_n     = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_te   = 0;
            prev_done = 0;
            te_n      = 0;
            tpg_n     = 0;
         end else begin
            if (tpg_load) tpg_n++;
            if (test_en) begin
               if (!prev_te) check("tpg_load_once", tpg_n, 1);
               check("pat_cnt_run", pat_cnt, te_n);
               te_n++;
            end
            if (!test_en && prev_te) begin
               if (!skip_len) check("test_en_len", te_n, N);
               te_n  = 0;
               tpg_n = 0;
            end
            if (bist_done && !prev_done) begin
               if (sb.size() == 0) begin
                  fail_now("done_unexpected");
               end else begin
                  e = sb.pop_front();
                  check("done_latency", cyc, e.done_cyc);
                  check("pass", bist_pass, e.pass);
                  check("pat_cnt_done", pat_cnt, N);
`ifdef BIST_SIG_LATCH_EN
                  check("sig_latched", sig_latched, e.sig);
`endif
               end
            end
            prev_te   = test_en;
            prev_done = bist_done;
         end
      end
   end

   // Expected: result appears N+3 edges after start is sampled.
   task automatic launch(input logic [3:0] sig);
      exp_t e;
      @(negedge clk);
      misr       = sig;
      start      = 1'b1;
      e.done_cyc = cyc + 1 + LAT;
      e.pass     = (sig == GOLD);
      e.sig      = sig;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic kick(input logic [3:0] sig);
      @(negedge clk);
      misr  = sig;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         fail_now("drain_timeout");
         sb.delete();
      end
   endtask

   task automatic wait_pat(input int k, output bit ok);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (test_en && pat_cnt == 4'(k)) ok = 1;
      end
   endtask

   task automatic wait_tpg(output bit ok);
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (tpg_load) ok = 1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tpg_load"}, tpg_load, 0);
      check({tag, "_test_en"}, test_en, 0);
      check({tag, "_misr_rst_n"}, misr_rst_n, 0);
      check({tag, "_pat_cnt"}, pat_cnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, bist_done, 0);
      check({tag, "_pass"}, bist_pass, 0);
   endtask

   task automatic hold_check(input logic exp_pass);
      repeat (4) @(negedge clk);
      check("done_hold", bist_done, 1);
      check("pass_hold", bist_pass, exp_pass);
      check("idle_busy_done", busy, 0);
      check("done_misr_rst_n", misr_rst_n, 1);
   endtask

   initial begin
      bit         ok;
      logic [3:0] s;
      exp_t       e1, e2;
      start = 1'b0;
      abort = 1'b0;
      misr  = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_misr_rst_n", misr_rst_n, 0);

      // Golden signature run, then result holds with start low.
      launch(GOLD);
      wait_tpg(ok);
      if (!ok) fail_now("init_seen");
      check("init_busy", busy, 1);
      check("init_misr_rst_n", misr_rst_n, 0);
      drain(40);
      hold_check(1'b1);

      // Rerun from a passing DONE with a bad signature.
      launch(4'h3);
      wait_tpg(ok);
      if (!ok) fail_now("rerun_init_seen");
      check("rerun_init_done", bist_done, 0);
      check("rerun_init_pass", bist_pass, 0);
      drain(40);
      hold_check(1'b0);
`ifdef BIST_SIG_LATCH_EN
      check("sig_latched_3", sig_latched, 4'h3);
`endif

      launch(4'h5);
      drain(40);
      hold_check(1'b0);

      // Abort mid-run at pat_cnt=3.
      skip_len = 1;
      kick(GOLD);
      wait_pat(3, ok);
      if (!ok) fail_now("reach_pat3");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_test_en", test_en, 0);
      check("abort_busy", busy, 0);
      check("abort_misr_rst_n", misr_rst_n, 0);
      check("abort_done", bist_done, 0);
      check("abort_pat_cnt", pat_cnt, 0);
      repeat (2) @(negedge clk);
      skip_len = 0;

      // Abort during COMPARE suppresses the result.
      kick(GOLD);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (busy && !test_en && !tpg_load && pat_cnt == 4'(N)) ok = 1;
      end
      if (!ok) fail_now("reach_compare");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("cmp_abort_done", bist_done, 0);
      check("cmp_abort_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("cmp_abort_done_later", bist_done, 0);
`ifdef BIST_SIG_LATCH_EN
      check("cmp_abort_sig", sig_latched, GOLD);
`endif

      // start held high: back-to-back runs, DONE lasts one cycle.
      @(negedge clk);
      misr        = GOLD;
      start       = 1'b1;
      e1.done_cyc = cyc + 1 + LAT;
      e1.pass     = 1'b1;
      e1.sig      = GOLD;
      e2          = e1;
      e2.done_cyc = e1.done_cyc + 1 + 1 + N + 1;
      sb.push_back(e1);
      sb.push_back(e2);
      for (int i = 0; i < 40 && sb.size() > 1; i++) begin
         @(negedge clk);
         #1;
      end
      start = 1'b0;
      drain(40);
      hold_check(1'b1);

      // Async reset mid-run at pat_cnt=5, no clock edge involved.
      kick(GOLD);
      wait_pat(5, ok);
      if (!ok) fail_now("reach_pat5");
      #2 rst_n = 1'b0;
      #1 check_all_zero("async");
`ifdef BIST_SIG_LATCH_EN
      check("async_sig", sig_latched, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_misr_rst_n", misr_rst_n, 0);
      check("post_rst_test_en", test_en, 0);
      check("post_rst_done", bist_done, 0);

      // Random runs: random signatures, about half golden.
      for (int r = 0; r < 10; r++) begin
         s = ($urandom_range(0, 1) == 1) ? GOLD : 4'($urandom_range(0, 15));
         launch(s);
         drain(40);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check("rand_done_hold", bist_done, 1);
         check("rand_pass_hold", bist_pass, s == GOLD);
      end

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
